frame_seq_detector: RTL and testbench
=====================================

# frame_seq_detector

Parametrised multi-pattern byte-sequence detector that sits on the laser receive path, after the receiver's `data_valid`/`data_in` byte stream. It matches NUM_SEQ programmable framing sequences (START/STOP/DATA/ACK and future ones), each SEQ_BYTES long, and reports which one completed. Unlike the previous fixed 4-byte detector, it:
- tracks every pattern independently, so first bytes need not be distinct;
- restarts on a mismatching byte that begins a new sequence;
- abandons a partial match after a configurable inter-byte gap.

## Interface
Parameters:
- NUM_SEQ, 4, number of patterns (1..16)
- SEQ_BYTES, 4, bytes per pattern (2..8)
- GAP_TIMEOUT, 64, idle cycles between valid bytes before partial matches are dropped; 0 disables
- IDX_W, max(1,$clog2(NUM_SEQ)), width of match_idx

Ports:
- Clock and reset (decided): one clock. Reset is asynchronous and active-low.
- clock  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low reset
- en  in  1  when low, all state frozen and data_valid ignored
- data_valid  in  1  one-cycle strobe, data_in valid
- data_in  in  8  received byte
- seq  in  NUM_SEQ×(8·SEQ_BYTES)  patterns; byte 0 is the MSB byte, matched first
- seq_mask  in  NUM_SEQ  pattern enable; 0 forces that pattern's progress to 0
- match  out  1  one-cycle pulse: at least one pattern completed
- match_vec  out  NUM_SEQ  patterns completed on that byte (valid with match, else 0)
- match_idx  out  IDX_W  lowest set index of match_vec (held until next match)
- busy  out  1  any pattern has progress > 0
- timeout  out  1  one-cycle pulse: gap timeout dropped a partial match

## Operation
- **Progress counters.** Each pattern i has a progress counter p[i], range 0..SEQ_BYTES-1, where p[i] is the number of bytes already matched.
- **Update rule.** Counters change only on a cycle with en=1, data_valid=1 and seq_mask[i]=1. Let b = data_in.
  - b == byte p[i] of seq[i]:
    - if p[i]==SEQ_BYTES-1: completion. Set bit i of next match_vec, then p[i] → 0.
    - otherwise p[i] → p[i]+1.
  - mismatch, and b == byte 0 of seq[i]: p[i] → 1.
  - mismatch otherwise: p[i] → 0.
- **Restart scope.** The restart rule is normative. Full KMP fallback is not provided, so a pattern whose first byte repeats inside itself can miss overlapping occurrences. The bench checks against this rule.
- **Frame boundary.** On any completion, all p[j] clear to 0 in the same update, including patterns that did not complete. This overrides their own update.
- **Priority.** Several patterns completing on one byte set all their match_vec bits; match_idx takes the lowest index.
- **Gap counter.** gap counts cycles with en=1, data_valid=0 and busy=1.
  - It clears on any valid byte, and on busy=0.
  - When gap reaches GAP_TIMEOUT, all p clear, timeout pulses, and gap clears.
  - GAP_TIMEOUT=0 disables the counter: gap stays 0 and timeout never asserts.
- **Frozen state (en=0).** p, gap and match_idx hold. match, match_vec and timeout are 0.
- **Mask deassertion.** A seq_mask bit going low clears that p on the next edge, regardless of en.
- **Pattern changes.** seq is sampled every cycle. Changing it mid-match is legal; progress is kept and compared against the new bytes.

## Timing
- Reset values: match=0, match_vec=0, match_idx=0, busy=0, timeout=0. All p=0, gap=0.
- Reset is asynchronous on assertion; release is synchronised by the system-level reset synchroniser.
- match / match_vec: registered. Asserted exactly 1 cycle after the clock edge sampling the final byte's data_valid, for 1 cycle.
- match_idx updates on the same edge as match and holds afterwards.
- busy: registered, reflects p after the update (1-cycle latency from the data_valid edge).
- timeout: asserted in the cycle after the edge on which gap reached GAP_TIMEOUT, i.e. GAP_TIMEOUT+1 cycles after the last valid byte's edge.
- Valid byte on the same edge gap would expire: the byte wins. gap clears, no timeout, and the byte is processed normally.
- Back-to-back data_valid every cycle is supported at full rate.
- Reset mid-frame: all progress lost immediately; no match or timeout pulse follows reset.

## Test plan
Setup: NUM_SEQ=4, SEQ_BYTES=4, seq={A1A2A3A4, D1D2D3D4, 51525354, C1C2C3C4} for indices 3..0, all masks 1.
- **Basic match.** GAP_TIMEOUT=64; C1,C2,C3,C4 spaced 3 idle cycles apart → one match pulse 1 cycle after the C4 edge; match_vec=0001; match_idx=0; busy 1→0.
- **Restart.** C1,C2,C1,C2,C3,C4 back-to-back → single match, idx 0. Then 51,C1,C2,C3,C4 → match idx 0. 51 alone never matches.
- **Gap timeout.** GAP_TIMEOUT=8; C1,C2, then 8 idle cycles → timeout pulse 9 cycles after the C2 edge, busy=0. Following C3,C4 → no match. Separately, a byte arriving on the 8th idle cycle → no timeout.
- **Simultaneous completion.** seq[1]=seq[3]=A1A2A3A4; feed A1..A4 → match_vec=1010, match_idx=1; all p clear.
- **Mask and enable.**
  - seq_mask=1110, feed C1..C4 → no match.
  - Mask restored; C1,C2, then en=0 for 100 cycles with valid bytes C3,C4 → no response. Then en=1 with C3,C4 → match idx 0, no timeout.
- **Reset mid-frame.** C1,C2,C3, then reset low for 2 cycles, then C4 → no match; all outputs 0 during and after reset.

Source files
------------

// File: rtl/frame_seq_detector.sv
// Multi-pattern framing-sequence detector on the receive byte stream.
// Each pattern has its own progress counter; a shared idle-gap counter drops stale partial matches.
module frame_seq_detector #(
    parameter int NUM_SEQ     = 4,
    parameter int SEQ_BYTES   = 4,
    parameter int GAP_TIMEOUT = 64,
    parameter int IDX_W       = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           data_valid,
    input  logic [7:0]                     data_in,
    input  logic [NUM_SEQ*8*SEQ_BYTES-1:0] seq,
    input  logic [NUM_SEQ-1:0]             seq_mask,
    output logic                           match,
    output logic [NUM_SEQ-1:0]             match_vec,
    output logic [IDX_W-1:0]               match_idx,
    output logic                           busy,
    output logic                           timeout
);

    localparam int               P_W     = $clog2(SEQ_BYTES);
    localparam int               GAP_W   = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [P_W-1:0]   P_LAST  = P_W'(SEQ_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_TIMEOUT);

    logic [7:0]         seq_byte [NUM_SEQ][SEQ_BYTES];
    logic [P_W-1:0]     p_q [NUM_SEQ];
    logic [P_W-1:0]     p_d [NUM_SEQ];
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_SEQ-1:0] complete;
    logic               match_q;
    logic [NUM_SEQ-1:0] match_vec_q;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    // Byte 0 of each pattern is its most significant byte and is matched first.
    for (genvar gi = 0; gi < NUM_SEQ; gi++) begin : g_seq
        for (genvar gk = 0; gk < SEQ_BYTES; gk++) begin : g_byte
            assign seq_byte[gi][gk] = seq[(gi*SEQ_BYTES + SEQ_BYTES - 1 - gk)*8 +: 8];
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        complete    = '0;
        gap_d       = gap_q;
        timeout_d   = 1'b0;
        match_idx_d = match_idx_q;
        busy_d      = 1'b0;

        for (int i = 0; i < NUM_SEQ; i++) begin
            p_d[i] = p_q[i];
            if (en && data_valid && seq_mask[i]) begin
                if (data_in == seq_byte[i][p_q[i]]) begin
                    if (p_q[i] == P_LAST) begin
                        complete[i] = 1'b1;
                        p_d[i]      = '0;
                    end else begin
                        p_d[i] = p_q[i] + P_W'(1);
                    end
                end else if (data_in == seq_byte[i][0]) begin
                    p_d[i] = P_W'(1);
                end else begin
                    p_d[i] = '0;
                end
            end
        end

        // A byte on the expiry edge resets the gap before the timeout can fire.
        if (en && GAP_TIMEOUT != 0) begin
            if (data_valid || !busy_q) begin
                gap_d = '0;
            end else if (gap_q == GAP_MAX) begin
                gap_d     = '0;
                timeout_d = 1'b1;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        for (int i = 0; i < NUM_SEQ; i++) begin
            if ((|complete) || timeout_d || !seq_mask[i]) begin
                p_d[i] = '0;
            end
            busy_d = busy_d | (p_d[i] != '0);
        end

        for (int i = NUM_SEQ - 1; i >= 0; i--) begin
            if (complete[i]) begin
                match_idx_d = IDX_W'(i);
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: p_q is a small flop array, not a RAM, so it is cleared with the rest of the state.
            for (int i = 0; i < NUM_SEQ; i++) begin
                p_q[i] <= '0;
            end
            gap_q       <= '0;
            match_q     <= 1'b0;
            match_vec_q <= '0;
            match_idx_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SEQ; i++) begin
                p_q[i] <= p_d[i];
            end
            gap_q       <= gap_d;
            match_q     <= |complete;
            match_vec_q <= complete;
            match_idx_q <= match_idx_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign match     = match_q;
    assign match_vec = match_vec_q;
    assign match_idx = match_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_frame_seq_detector.sv
// Scenario tasks plus a randomized run for frame_seq_detector, checked against a
// per-pattern progress model and an idle-since-last-byte timeout model.
module tb_frame_seq_detector;

    localparam int NS  = 4;
    localparam int SB  = 4;
    localparam int GAP = 8;
    localparam int IW  = 2;
    localparam int OW  = NS + IW + 3;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              data_valid;
    logic [7:0]        data_in;
    logic [NS*SB*8-1:0] seq;
    logic [NS-1:0]     seq_mask;
    logic              match;
    logic [NS-1:0]     match_vec;
    logic [IW-1:0]     match_idx;
    logic              busy;
    logic              timeout;

    frame_seq_detector #(
        .NUM_SEQ    (NS),
        .SEQ_BYTES  (SB),
        .GAP_TIMEOUT(GAP),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_valid(data_valid),
        .data_in   (data_in),
        .seq       (seq),
        .seq_mask  (seq_mask),
        .match     (match),
        .match_vec (match_vec),
        .match_idx (match_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] pat [NS][SB];
    int         prog [NS];
    int         idle;
    logic          exp_match, exp_busy, exp_timeout;
    logic [NS-1:0] exp_vec;
    logic [IW-1:0] exp_idx;

    function automatic logic [OW-1:0] obs();
        return {match, match_vec, match_idx, busy, timeout};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {exp_match, exp_vec, exp_idx, exp_busy, exp_timeout};
    endfunction

    task automatic pack();
        for (int i = 0; i < NS; i++)
            for (int k = 0; k < SB; k++)
                seq[(i*SB + SB - 1 - k)*8 +: 8] = pat[i][k];
    endtask

    task automatic load_default();
        pat[0] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        pat[1] = '{8'h51, 8'h52, 8'h53, 8'h54};
        pat[2] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        pat[3] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        pack();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) prog[i] = 0;
        idle        = 0;
        exp_match   = 1'b0;
        exp_vec     = '0;
        exp_idx     = '0;
        exp_busy    = 1'b0;
        exp_timeout = 1'b0;
    endtask

    // Reference: progress = bytes matched so far; timeout = (GAP+1)th enabled idle
    // edge since the last valid byte while some progress is held.
    task automatic model_edge();
        int            np [NS];
        logic [NS-1:0] comp;
        logic          was_busy;
        logic          fire;
        logic          found;
        comp     = '0;
        was_busy = 1'b0;
        fire     = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < NS; i++) if (prog[i] != 0) was_busy = 1'b1;
        for (int i = 0; i < NS; i++) begin
            np[i] = prog[i];
            if (en && data_valid && seq_mask[i]) begin
                if (data_in == pat[i][prog[i]]) np[i] = prog[i] + 1;
                else if (data_in == pat[i][0])  np[i] = 1;
                else                            np[i] = 0;
                if (np[i] == SB) comp[i] = 1'b1;
            end
        end
        if (en) begin
            if (data_valid) idle = 0;
            else begin
                idle++;
                fire = (GAP > 0) && was_busy && (idle == GAP + 1);
            end
        end
        exp_match   = |comp;
        exp_vec     = comp;
        exp_timeout = fire;
        exp_busy    = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if ((comp != 0) || fire || !seq_mask[i]) np[i] = 0;
            prog[i] = np[i];
            if (prog[i] != 0) exp_busy = 1'b1;
            if (comp[i] && !found) begin
                exp_idx = IW'(i);
                found   = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic e, input logic v, input logic [7:0] b);
        en         = e;
        data_valid = v;
        data_in    = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        en         = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        seq_mask   = '1;
        load_default();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_hold: got %b want %b", obs(), {OW{1'b0}}); end
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_release: got %b want %b", obs(), {OW{1'b0}}); end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 1'b1, bytes[n]);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL basic_model byte%0d: got %b want %b", n, obs(), expv()); end
            total++;
            if (n < 3) begin
                if ({match, busy} !== 2'b01) begin bad++; $display("FAIL basic_partial byte%0d: got match,busy=%b want 01", n, {match, busy}); end
            end else if ({match, match_vec, match_idx, busy} !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
                bad++; $display("FAIL basic_match: got %b want %b", {match, match_vec, match_idx, busy}, {1'b1, 4'b0001, 2'd0, 1'b0});
            end
            for (int k = 0; k < 3; k++) begin
                cycle(1'b1, 1'b0, 8'h00);
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL basic_idle byte%0d/%0d: got %b want %b", n, k, obs(), expv()); end
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] s1 [6] = '{8'hC1, 8'hC2, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        logic [7:0] s2 [5] = '{8'h51, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        int pulses;
        int touts;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, 1'b1, s1[n]);
            pulses += int'(match);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL restart1_model byte%0d: got %b want %b", n, obs(), expv()); end
        end
        total++;
        if (pulses !== 1 || match_idx !== 2'd0) begin bad++; $display("FAIL restart1_count: got pulses=%0d idx=%0d want 1/0", pulses, match_idx); end
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 1'b1, s2[n]);
            pulses += int'(match);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL restart2_model byte%0d: got %b want %b", n, obs(), expv()); end
        end
        total++;
        if (pulses !== 1 || match_idx !== 2'd0) begin bad++; $display("FAIL restart2_count: got pulses=%0d idx=%0d want 1/0", pulses, match_idx); end
        pulses = 0;
        touts  = 0;
        cycle(1'b1, 1'b1, 8'h51);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            pulses += int'(match);
            touts  += int'(timeout);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL lone51_model idle%0d: got %b want %b", k, obs(), expv()); end
        end
        total++;
        if (pulses !== 0 || touts !== 1) begin bad++; $display("FAIL lone51_count: got match=%0d timeout=%0d want 0/1", pulses, touts); end
    endtask

    task automatic test_gap();
        int pulses;
        cycle(1'b1, 1'b1, 8'hC1);
        cycle(1'b1, 1'b1, 8'hC2);
        for (int n = 1; n <= GAP + 1; n++) begin
            cycle(1'b1, 1'b0, 8'h00);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL gap_model idle%0d: got %b want %b", n, obs(), expv()); end
            if (n == GAP) begin
                total++;
                if ({timeout, busy} !== 2'b01) begin bad++; $display("FAIL gap_before: got timeout,busy=%b want 01", {timeout, busy}); end
            end
        end
        total++;
        if ({timeout, busy} !== 2'b10) begin bad++; $display("FAIL gap_expire: got timeout,busy=%b want 10", {timeout, busy}); end
        pulses = 0;
        cycle(1'b1, 1'b0, 8'h00);
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL gap_pulse_width: got timeout=%b want 0", timeout); end
        cycle(1'b1, 1'b1, 8'hC3);
        pulses += int'(match);
        cycle(1'b1, 1'b1, 8'hC4);
        pulses += int'(match);
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL gap_no_match_after: got %0d matches want 0", pulses); end
        cycle(1'b1, 1'b1, 8'hC1);
        cycle(1'b1, 1'b1, 8'hC2);
        repeat (GAP) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hC3);
        total++;
        if ({timeout, busy} !== 2'b01) begin bad++; $display("FAIL gap_byte_wins: got timeout,busy=%b want 01", {timeout, busy}); end
        cycle(1'b1, 1'b1, 8'hC4);
        total++;
        if ({match, match_idx, timeout} !== {1'b1, 2'd0, 1'b0}) begin
            bad++; $display("FAIL gap_byte_wins_match: got %b want %b", {match, match_idx, timeout}, {1'b1, 2'd0, 1'b0});
        end
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_simul();
        logic [7:0] s [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        pat[1] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        pat[2] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        pack();
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 1'b1, s[n]);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL simul_model byte%0d: got %b want %b", n, obs(), expv()); end
            if (n == 3) begin
                total++;
                if ({match, match_vec, match_idx, busy} !== {1'b1, 4'b1010, 2'd1, 1'b0}) begin
                    bad++; $display("FAIL simul_match: got %b want %b", {match, match_vec, match_idx, busy}, {1'b1, 4'b1010, 2'd1, 1'b0});
                end
            end
        end
        total++;
        if ({match, busy} !== 2'b00) begin bad++; $display("FAIL simul_frame_clear: got match,busy=%b want 00", {match, busy}); end
        load_default();
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_mask_en();
        logic [7:0] s [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        int pulses;
        int touts;
        pulses   = 0;
        seq_mask = 4'b1110;
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 1'b1, s[n]);
            pulses += int'(match);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL mask_model byte%0d: got %b want %b", n, obs(), expv()); end
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL mask_no_match: got %0d matches want 0", pulses); end
        seq_mask = '1;
        cycle(1'b1, 1'b1, 8'hC1);
        cycle(1'b1, 1'b1, 8'hC2);
        pulses = 0;
        touts  = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, (k == 40 || k == 41), (k == 41) ? 8'hC4 : 8'hC3);
            pulses += int'(match);
            touts  += int'(timeout);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL en_low_model cyc%0d: got %b want %b", k, obs(), expv()); end
        end
        total++;
        if (pulses !== 0 || touts !== 0 || busy !== 1'b1) begin
            bad++; $display("FAIL en_low_frozen: got match=%0d timeout=%0d busy=%b want 0/0/1", pulses, touts, busy);
        end
        cycle(1'b1, 1'b1, 8'hC3);
        cycle(1'b1, 1'b1, 8'hC4);
        total++;
        if ({match, match_idx, timeout} !== {1'b1, 2'd0, 1'b0}) begin
            bad++; $display("FAIL en_resume_match: got %b want %b", {match, match_idx, timeout}, {1'b1, 2'd0, 1'b0});
        end
        cycle(1'b1, 1'b1, 8'hC1);
        seq_mask = 4'b1110;
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mask_drop_while_frozen: got busy=%b want 0", busy); end
        seq_mask = '1;
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b1, 8'hC1);
        cycle(1'b1, 1'b1, 8'hC2);
        cycle(1'b1, 1'b1, 8'hC3);
        en         = 1'b0;
        data_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_mid_async: got %b want %b", obs(), {OW{1'b0}}); end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_mid_hold: got %b want %b", obs(), {OW{1'b0}}); end
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 8'hC4);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_mid_c4: got %b want %b", obs(), {OW{1'b0}}); end
        for (int k = 0; k < GAP + 3; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            total++;
            if (obs() !== '0) begin bad++; $display("FAIL reset_mid_after idle%0d: got %b want %b", k, obs(), {OW{1'b0}}); end
        end
    endtask

    task automatic test_random();
        int         dvp;
        int         tgt;
        int         r;
        int         seen_match;
        int         seen_tout;
        logic [7:0] b;
        seen_match = 0;
        seen_tout  = 0;
        tgt        = 0;
        for (int blk = 0; blk < 20; blk++) begin
            dvp = (blk % 3 == 0) ? 90 : (blk % 3 == 1) ? 60 : 15;
            if (blk == 10) begin
                for (int i = 0; i < NS; i++)
                    for (int k = 0; k < SB; k++)
                        pat[i][k] = 8'h10 + 8'($urandom_range(3));
                pack();
            end
            for (int c = 0; c < 150; c++) begin
                if (c % 20 == 0) tgt = $urandom_range(NS - 1);
                seq_mask = ($urandom_range(99) < 3) ? 4'($urandom) : 4'hF;
                if ($urandom_range(299) == 0) begin
                    pat[$urandom_range(NS - 1)][$urandom_range(SB - 1)] = (blk < 10) ? 8'($urandom) : 8'h10 + 8'($urandom_range(3));
                    pack();
                end
                r = $urandom_range(99);
                if (r < 60)      b = pat[tgt][prog[tgt]];
                else if (blk < 10 && r < 90) b = pat[$urandom_range(NS - 1)][$urandom_range(SB - 1)];
                else if (blk >= 10) b = 8'h10 + 8'($urandom_range(3));
                else             b = 8'($urandom);
                cycle(($urandom_range(99) < 92), ($urandom_range(99) < dvp), b);
                seen_match += int'(match);
                seen_tout  += int'(timeout);
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL random blk%0d cyc%0d: got %b want %b", blk, c, obs(), expv()); end
            end
        end
        total++;
        if (seen_match == 0 || seen_tout == 0) begin
            bad++; $display("FAIL random_coverage: got matches=%0d timeouts=%0d want both >0", seen_match, seen_tout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_gap();
        test_simul();
        test_mask_en();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
